// File: rtl/cpu_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_I    = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;

endpackage

// File: rtl/arb_select.sv
// Winner selection between fetch and data requests; data wins unless fetch has waited too long.
module arb_select
    import cpu_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_dm_req,
    input  logic       i_streak_max,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_dm_req && !(i_if_req && i_streak_max)) begin
            o_gnt = GNT_D;
        end else if (i_if_req) begin
            o_gnt = GNT_I;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and data-stage accesses onto one variable-latency memory port,
// with a fetch starvation guard and redirect-driven fetch kill.
module unified_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MAX_STREAK    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDRESS_WIDTH-1:0]  if_addr,
    input  logic                      if_kill,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_valid,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [ADDRESS_WIDTH-1:0]  dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wdata,
    input  logic [DATA_WIDTH/8-1:0]   dm_be,
    output logic [DATA_WIDTH-1:0]     dm_rdata,
    output logic                      dm_valid,
    output logic                      stall_if,
    output logic                      stall_dm,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_ready
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    arb_state_t                r_state;
    logic [STREAK_W-1:0]       r_streak;
    logic                      r_kill;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [ADDRESS_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_wdata;
    logic [DATA_WIDTH/8-1:0]   r_mem_be;
    logic [DATA_WIDTH-1:0]     r_if_rdata;
    logic                      r_if_valid;
    logic [DATA_WIDTH-1:0]     r_dm_rdata;
    logic                      r_dm_valid;

    logic [1:0]                w_gnt;
    logic                      w_streak_max;
    logic                      w_if_drop;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
        return (v == STREAK_MAX) ? v : v + STREAK_W'(1);
    endfunction

    assign w_streak_max = (r_streak == STREAK_MAX);
    // A redirect seen at any point of the fetch, including its final cycle, drops the result.
    assign w_if_drop    = r_kill | if_kill;

    arb_select u_arb_select (
        .i_if_req     (if_req),
        .i_dm_req     (dm_req),
        .i_streak_max (w_streak_max),
        .o_gnt        (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_kill <= 1'b0;
                    if (w_gnt == GNT_D) begin
                        r_state     <= BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_mem_be    <= dm_be;
                        r_streak    <= if_req ? sat_inc(r_streak) : '0;
                    end else if (w_gnt == GNT_I) begin
                        r_state     <= BUSY_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '0;
                        r_streak    <= '0;
                    end
                end
                BUSY_I: begin
                    if (mem_ready) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_kill    <= 1'b0;
                        if (!w_if_drop) begin
                            r_if_rdata <= mem_rdata;
                            r_if_valid <= 1'b1;
                        end
                    end else if (if_kill) begin
                        r_kill <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        r_state    <= IDLE;
                        r_mem_req  <= 1'b0;
                        r_dm_rdata <= mem_rdata;
                        r_dm_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign stall_if  = if_req & ~r_if_valid;
    assign stall_dm  = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model and a variable-latency memory responder.
module tb_unified_mem_arbiter;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MS = 4;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req, if_kill, if_valid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [BW-1:0] dm_be;
    logic          stall_if, stall_dm;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Backing memory: ready comes lat cycles after the first cycle mem_req is seen.
    int lat_cfg  = 2;
    bit rand_lat = 1'b0;
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_req || mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                cnt = 0;
            end else begin
                if (cnt == 0) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : lat_cfg;
                if (cnt == cur_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_fn(mem_addr);
                end else begin
                    mem_rdata = $urandom;
                end
                cnt++;
            end
        end
    end

    // Reference model: one transaction at a time, grants decided from the previous cycle's requests.
    int            m_own = 0, m_exp_v = 0, m_streak = 0;
    bit            m_exp_kill = 0, m_killed = 0;
    bit            m_prev_rst = 1, m_prev_mreq = 0, m_prev_ready = 0;
    bit            m_prev_ireq = 0, m_prev_dreq = 0, m_prev_dwe = 0;
    logic [AW-1:0] m_prev_iaddr = '0, m_prev_daddr = '0, m_h_addr = '0;
    logic [DW-1:0] m_prev_dwdata = '0, m_h_wdata = '0, m_exp_data = '0;
    logic [BW-1:0] m_prev_dbe = '0, m_h_be = '0;
    bit            m_h_we = 0;
    int            gseq[$];

    initial begin
        forever begin
            @(negedge clk);
            if (m_prev_rst) begin
                chk("rst_mem_req", mem_req, 0);
                chk("rst_if_valid", if_valid, 0);
                chk("rst_dm_valid", dm_valid, 0);
                m_own = 0; m_exp_v = 0; m_killed = 0; m_streak = 0;
            end else begin
                chk("if_valid", if_valid, (m_exp_v == 1 && !m_exp_kill));
                chk("dm_valid", dm_valid, (m_exp_v == 2));
                if (m_exp_v == 1 && !m_exp_kill) chk("if_rdata", if_rdata, m_exp_data);
                if (m_exp_v == 2) chk("dm_rdata", dm_rdata, m_exp_data);
                m_exp_v = 0;
                if (m_prev_ready) begin
                    chk("mem_req_drop", mem_req, 0);
                    m_own = 0;
                end else if (m_prev_mreq) begin
                    chk("mem_req_hold", mem_req, 1);
                    chk("hold_addr", mem_addr, m_h_addr);
                    chk("hold_we", mem_we, m_h_we);
                    chk("hold_be", mem_be, m_h_be);
                    if (m_own == 2) chk("hold_wdata", mem_wdata, m_h_wdata);
                end else if (m_prev_ireq || m_prev_dreq) begin
                    chk("grant", mem_req, 1);
                    if (m_prev_dreq && !(m_prev_ireq && m_streak == MS)) begin
                        m_own = 2;
                        m_h_addr = m_prev_daddr; m_h_we = m_prev_dwe;
                        m_h_be = m_prev_dbe; m_h_wdata = m_prev_dwdata;
                        m_streak = m_prev_ireq ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
                        chk("grant_wdata", mem_wdata, m_h_wdata);
                    end else begin
                        m_own = 1;
                        m_h_addr = m_prev_iaddr; m_h_we = 1'b0; m_h_be = '0;
                        m_streak = 0;
                    end
                    chk("grant_addr", mem_addr, m_h_addr);
                    chk("grant_we", mem_we, m_h_we);
                    chk("grant_be", mem_be, m_h_be);
                    m_killed = 0;
                    gseq.push_back(m_own);
                end else begin
                    chk("idle_no_req", mem_req, 0);
                end
                if (m_own == 1 && if_kill) m_killed = 1;
                if (mem_ready) begin
                    m_exp_v = m_own; m_exp_kill = m_killed; m_exp_data = mem_rdata;
                end
            end
            chk("stall_if", stall_if, if_req & ~if_valid);
            chk("stall_dm", stall_dm, dm_req & ~dm_valid);
            m_prev_rst = rst; m_prev_mreq = mem_req; m_prev_ready = mem_ready;
            m_prev_ireq = if_req; m_prev_iaddr = if_addr;
            m_prev_dreq = dm_req; m_prev_dwe = dm_we; m_prev_daddr = dm_addr;
            m_prev_dwdata = dm_wdata; m_prev_dbe = dm_be;
        end
    end

    initial begin
        int tv_i, tv_d, nbusy, n_valid;
        bit seen, saw_hs, hs_prev;
        logic [DW-1:0] rdata_before, vdata;
        if_req = 0; if_addr = '0; if_kill = 0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        repeat (2) tick();
        rst = 0;
        sample();
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_mem_be", mem_be, 0);
        chk("reset_if_rdata", if_rdata, 0);
        chk("reset_dm_rdata", dm_rdata, 0);

        // Single fetch, ready two cycles after mem_req.
        lat_cfg = 2;
        for (int c = 0; c <= 4; c++) begin
            tick();
            if (c == 0) begin if_req = 1; if_addr = 32'h100; end
            if (c == 4) if_req = 0;
            sample();
            if (c < 4) begin
                chk("sf_stall", stall_if, 1);
                chk("sf_valid_low", if_valid, 0);
            end else begin
                chk("sf_valid", if_valid, 1);
                chk("sf_rdata", if_rdata, 32'h00500093);
            end
            if (c == 1) chk("sf_mem_addr", mem_addr, 32'h100);
        end
        tick(); sample();
        chk("sf_pulse", if_valid, 0);

        // Contention: data wins first.
        lat_cfg = 1;
        tick();
        if_req = 1; if_addr = 32'h180;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_be = '0;
        sample(); tick(); sample();
        chk("ct_mem_req", mem_req, 1);
        chk("ct_mem_addr", mem_addr, 32'h2000);
        chk("ct_mem_we", mem_we, 0);
        tv_i = -1; tv_d = -1;
        for (int c = 0; c < 20 && (tv_i < 0 || tv_d < 0); c++) begin
            tick();
            if (dm_valid && tv_d < 0) begin tv_d = c; dm_req = 0; chk("ct_dm_rdata", dm_rdata, rd_fn(32'h2000)); end
            if (if_valid && tv_i < 0) begin tv_i = c; if_req = 0; chk("ct_if_rdata", if_rdata, rd_fn(32'h180)); end
        end
        chk("ct_both_done", (tv_i >= 0 && tv_d >= 0), 1);
        chk("ct_order", (tv_d < tv_i), 1);

        // Write held until ready.
        lat_cfg = 3;
        tick();
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        sample();
        nbusy = 0; seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dm_valid) begin seen = 1; dm_req = 0; dm_we = 0; end
            sample();
            if (mem_req) begin
                nbusy++;
                chk("wr_we", mem_we, 1);
                chk("wr_addr", mem_addr, 32'h40);
                chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
                chk("wr_be", mem_be, 4'b0011);
            end
            if (seen) break;
        end
        chk("wr_valid", seen, 1);
        chk("wr_busy_cycles", nbusy, 4);

        // Kill an in-flight fetch, then redirect to 0x300.
        lat_cfg = 3;
        tick(); if_req = 1; if_addr = 32'h200; sample();
        for (int c = 0; c < 10; c++) begin tick(); sample(); if (mem_req) break; end
        chk("kl_busy", mem_req, 1);
        rdata_before = if_rdata;
        tick(); if_kill = 1; if_addr = 32'h300; sample();
        n_valid = 0; saw_hs = 0; hs_prev = 0; vdata = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if_kill = 0;
            if (if_valid) begin n_valid++; vdata = if_rdata; if_req = 0; end
            sample();
            if (hs_prev) begin
                chk("kl_no_valid", if_valid, 0);
                chk("kl_rdata_kept", if_rdata, rdata_before);
                hs_prev = 0;
            end
            if (mem_ready && mem_addr == 32'h200) begin saw_hs = 1; hs_prev = 1; end
            if (n_valid > 0) break;
        end
        chk("kl_handshake", saw_hs, 1);
        chk("kl_valid_count", n_valid, 1);
        chk("kl_new_rdata", vdata, rd_fn(32'h300));

        // Reset during a data transaction that built up a streak.
        lat_cfg = 10;
        tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h3300; if_req = 1; if_addr = 32'h600;
        sample();
        for (int c = 0; c < 10; c++) begin tick(); sample(); if (mem_req) break; end
        chk("rs_busy_d", mem_addr, 32'h3300);
        tick(); rst = 1; dm_req = 0; if_req = 0; sample();
        tick(); rst = 0; sample();
        chk("rs_mem_req", mem_req, 0);
        chk("rs_state", dut.r_state, IDLE);
        chk("rs_streak", dut.r_streak, 0);
        chk("rs_mem_addr", mem_addr, 0);
        chk("rs_dm_rdata", dm_rdata, 0);
        for (int c = 0; c < 12; c++) begin
            tick(); sample();
            chk("rs_no_dm_valid", dm_valid, 0);
        end

        // Starvation guard: data held continuously with fetch pending.
        lat_cfg = 0;
        gseq.delete();
        tick();
        if_req = 1; if_addr = 32'h500;
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
        for (int c = 0; c < 60 && gseq.size() < 6; c++) begin
            tick();
            if (if_valid) if_req = 0;
            sample();
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (if_valid) if_req = 0;
            if (dm_valid) begin dm_req = 0; break; end
        end
        chk("sv_grants", (gseq.size() >= 6), 1);
        if (gseq.size() >= 6) begin
            for (int i = 0; i < 4; i++) chk("sv_data_grant", gseq[i], 2);
            chk("sv_fetch_grant", gseq[4], 1);
            chk("sv_data_resume", gseq[5], 2);
        end

        // Randomized traffic.
        rand_lat = 1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (if_req) begin
                if (if_valid) begin
                    if ($urandom_range(0, 3) != 0) if_addr = 32'($urandom_range(0, 1023)) << 2;
                    else if_req = 0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                if_req = 1; if_addr = 32'($urandom_range(0, 1023)) << 2;
            end
            if_kill = ($urandom_range(0, 15) == 0);
            if (if_kill && if_req) if_addr = 32'($urandom_range(0, 1023)) << 2;
            if (!dm_req || dm_valid) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = 32'($urandom_range(0, 4095)) << 2;
                dm_wdata = $urandom;
                dm_be    = 4'($urandom_range(0, 15));
            end
        end
        if_kill = 0;
        for (int c = 0; c < 100 && (if_req || dm_req); c++) begin
            tick();
            if (if_valid) if_req = 0;
            if (dm_valid) dm_req = 0;
        end
        chk("drain", {if_req, dm_req}, 2'b00);
        tick(); sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the fetch stage (instruction port) and the memory stage (data port) of the 5-stage pipeline.
- Accepts requests from both ports and serializes them. Data requests have priority, with a starvation guard for fetch.
- Produces per-port stall signals for the hazard logic.
- Supports killing an in-flight fetch on a branch or jump redirect (pc_src_e).

Parameters:
- DATA_WIDTH, 32, width of the data/instruction word
- ADDRESS_WIDTH, 32, width of the byte address
- MAX_STREAK, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win (≥1)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDRESS_WIDTH  fetch address; stable while if_req=1 and not yet served
- if_kill  in  1  discard the in-flight fetch result (redirect)
- if_rdata  out  DATA_WIDTH  fetched instruction; valid only when if_valid=1
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDRESS_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_be  in  DATA_WIDTH/8  byte enables for writes
- dm_rdata  out  DATA_WIDTH  load data; valid only when dm_valid=1
- dm_valid  out  1  one-cycle completion pulse for data (reads and writes)
- stall_if  out  1  if_req & ~if_valid (combinational)
- stall_dm  out  1  dm_req & ~dm_valid (combinational)
- mem_req  out  1  request to the backing memory; held until mem_ready
- mem_we, mem_addr, mem_wdata, mem_be  out  1 / ADDRESS_WIDTH / DATA_WIDTH / DATA_WIDTH/8  registered copy of the granted request
- mem_rdata  in  DATA_WIDTH  read data; sampled when mem_ready=1
- mem_ready  in  1  transaction complete; must never be 1 while mem_req=0

Behaviour:
- Reset values (clk and rst are the only clock/reset): state=IDLE; mem_req=0; mem_we=0; mem_addr/wdata/be=0; if_valid=0; dm_valid=0; if_rdata=0; dm_rdata=0; streak=0; kill_flag=0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated every IDLE cycle:
  - Only dm_req=1: grant D.
  - Only if_req=1: grant I.
  - Both: grant I if streak==MAX_STREAK, else grant D.
  - On a grant: capture addr/we/wdata/be into the mem_* registers, set mem_req=1, and move to BUSY_I or BUSY_D at the next edge.
  - Fetch grants drive mem_we=0 and mem_be=0.
- Streak counter:
  - D grant with if_req=1: streak+1, saturating at MAX_STREAK.
  - I grant: streak=0.
  - D grant with if_req=0: streak=0.
- BUSY_x: mem_req stays 1 and the mem_* registers stay stable until mem_ready=1. On that edge:
  - mem_req goes to 0 and the FSM returns to IDLE.
  - The port's rdata register loads mem_rdata.
  - The port's valid is 1 for exactly the following cycle.
- Latency: request seen in IDLE cycle 0 → mem_req=1 in cycle 1 → mem_ready in cycle k≥1 → valid in cycle k+1. Minimum is 3 cycles (request to valid), with one forced IDLE cycle between transactions.
- A req that is high in the cycle its own valid is high counts as a new request. Requesters drop req in that cycle if they have nothing further.
- Data writes: dm_valid pulses on completion. dm_rdata is loaded with mem_rdata but is don't-care to consumers.
- if_kill:
  - Sampled in BUSY_I, including the mem_ready cycle: sets kill_flag.
  - On completion with kill_flag=1 or if_kill=1: if_valid stays 0 and if_rdata is unchanged. kill_flag clears on leaving BUSY_I.
  - In IDLE or BUSY_D: no effect. An if_req present in IDLE together with if_kill is arbitrated normally, since it carries the new target.
- The memory transaction is never aborted by if_kill. The bus handshake always completes.
- rst mid-transaction: return to IDLE next edge and apply all reset values. No valid is produced for the aborted transaction. The backing memory is reset on the same rst.
- stall_if/stall_dm are purely combinational from req/valid. A killed fetch keeps stall_if=1 until a later fetch completes.

Decomposition:
- Shared package (cpu_pkg):
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D}
  - grant encoding constants GNT_NONE/GNT_I/GNT_D
- One sub-module, arb_select: combinational winner selection from if_req, dm_req, and streak==MAX_STREAK, returning the grant code. The FSM, streak counter, and capture registers stay in unified_mem_arbiter.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_ready asserted 2 cycles after mem_req with mem_rdata=0x00500093 → if_valid pulse in cycle 4, if_rdata=0x00500093, stall_if=1 in cycles 0–3.
- Contention: if_req=1 and dm_req=1 (read, dm_addr=0x2000) in the same IDLE cycle → data is granted first (mem_addr=0x2000, mem_we=0), then fetch; dm_valid precedes if_valid.
- Starvation guard with MAX_STREAK=4:
  - Stimulus: dm_req held high continuously with if_req high.
  - Required: exactly 4 data grants, then 1 fetch grant, then the data grants resume.
- Kill: fetch of 0x200 in BUSY_I, if_kill=1 for one cycle before mem_ready → no if_valid, memory handshake completes. Next fetch of 0x300 returns normally.
- Write: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, dm_be=4'b0011 → mem_we=1 with the same addr/data/be held until mem_ready, then a dm_valid pulse.
- Reset mid-operation: rst=1 while in BUSY_D with mem_ready still low → next cycle mem_req=0, state IDLE, no dm_valid, streak=0.
